// File: rtl/vc_out_scheduler.sv
// Output-port scheduler: per-VC round-robin with wormhole lock,
// fixed VC priority gated by downstream credits, registered link.
module vc_out_scheduler #(
  parameter int N_INPUTS = 4,
  parameter int N_VCS    = 3,
  parameter int FLIT_W   = 37,
  parameter int CREDITS  = 2
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [N_INPUTS*FLIT_W-1:0]   in_flit_i,
  output logic [N_INPUTS-1:0]          in_ready_o,
  input  logic [N_VCS-1:0]             credit_i,
  output logic [FLIT_W-1:0]            out_flit_o,
  output logic [N_VCS-1:0]             vc_locked_o,
  output logic                         credit_err_o
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int VW = (N_VCS > 1) ? $clog2(N_VCS) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  logic [N_VCS-1:0]          r_lock;
  logic [N_VCS-1:0][IW-1:0]  r_owner;
  logic [N_VCS-1:0][IW-1:0]  r_ptr;
  logic [N_VCS-1:0][CW-1:0]  r_cred;
  logic [FLIT_W-1:0]         r_out;
  logic                      r_err;

  logic [FLIT_W-1:0]              w_fl [N_INPUTS];
  logic [N_VCS-1:0][N_INPUTS-1:0] w_cand;
  logic [N_VCS-1:0]               w_has;
  logic [N_VCS-1:0][IW-1:0]       w_pick;
  logic                           w_any;
  logic [VW-1:0]                  w_gnt_vc;
  logic [IW-1:0]                  w_gnt_in;
  logic [IW-1:0]                  w_ptr_nx;
  logic [N_VCS-1:0]               w_dec;
  logic [FLIT_W-1:0]              w_win;
  logic [1:0]                     w_typ;
  logic [7:0]                     w_len;

  always_comb begin
    for (int n = 0; n < N_INPUTS; n++) begin
      w_fl[n] = in_flit_i[n*FLIT_W +: FLIT_W];
    end
  end

  // A locked VC only admits body/tail from its owner; unlocked only heads.
  always_comb begin
    w_cand = '0;
    for (int v = 0; v < N_VCS; v++) begin
      for (int n = 0; n < N_INPUTS; n++) begin
        if (w_fl[n][0] && (int'(w_fl[n][2:1]) == v)) begin
          if (!r_lock[v])
            w_cand[v][n] = (w_fl[n][33:32] == 2'b00);
          else
            w_cand[v][n] = (r_owner[v] == IW'(n)) &&
                           ((w_fl[n][33:32] == 2'b01) ||
                            (w_fl[n][33:32] == 2'b10));
        end
      end
    end
  end

  always_comb begin
    w_has  = '0;
    w_pick = '0;
    for (int v = 0; v < N_VCS; v++) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        if (!w_has[v] &&
            w_cand[v][(int'(r_ptr[v]) + k) % N_INPUTS]) begin
          w_has[v]  = 1'b1;
          w_pick[v] = IW'((int'(r_ptr[v]) + k) % N_INPUTS);
        end
      end
    end
  end

  // Ascending scan so the highest eligible VC is the last to overwrite.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_vc = '0;
    w_gnt_in = '0;
    for (int v = 0; v < N_VCS; v++) begin
      if (w_has[v] && (r_cred[v] != '0)) begin
        w_any    = 1'b1;
        w_gnt_vc = VW'(v);
        w_gnt_in = w_pick[v];
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    w_dec      = '0;
    if (w_any) begin
      in_ready_o[w_gnt_in] = 1'b1;
      w_dec[w_gnt_vc]      = 1'b1;
    end
  end

  assign w_win    = w_fl[w_gnt_in];
  assign w_typ    = w_win[33:32];
  assign w_len    = w_win[29:22];
  assign w_ptr_nx = IW'((int'(w_gnt_in) + 1) % N_INPUTS);

  always_ff @(posedge clk) begin
    if (arst) begin
      r_lock  <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
      for (int v = 0; v < N_VCS; v++) r_cred[v] <= CW'(CREDITS);
    end else begin
      r_out <= w_any ? w_win : '0;
      for (int v = 0; v < N_VCS; v++) begin
        if (w_dec[v] && !credit_i[v]) begin
          r_cred[v] <= r_cred[v] - CW'(1);
        end else if (!w_dec[v] && credit_i[v]) begin
          if (r_cred[v] == CW'(CREDITS)) r_err <= 1'b1;
          else r_cred[v] <= r_cred[v] + CW'(1);
        end
        if (w_dec[v]) begin
          if (w_typ == 2'b00) begin
            r_ptr[v] <= w_ptr_nx;
            if (w_len != 8'd0) begin
              r_lock[v]  <= 1'b1;
              r_owner[v] <= w_gnt_in;
            end
          end else if (w_typ == 2'b10) begin
            r_lock[v] <= 1'b0;
          end
        end
      end
    end
  end

  assign out_flit_o   = r_out;
  assign vc_locked_o  = r_lock;
  assign credit_err_o = r_err;

endmodule

// File: tb/tb_vc_out_scheduler.sv
// Directed bench for vc_out_scheduler: RR, wormhole lock,
// credit stall, VC priority, credit error and mid-packet reset.
module tb_vc_out_scheduler;

  logic         clk = 1'b0;
  logic         arst;
  logic [147:0] in_flit;
  logic [3:0]   in_ready;
  logic [2:0]   credit;
  logic [36:0]  out_flit;
  logic [2:0]   vc_locked;
  logic         cerr;

  int total = 0;
  int bad   = 0;

  vc_out_scheduler dut (
    .clk          (clk),
    .arst         (arst),
    .in_flit_i    (in_flit),
    .in_ready_o   (in_ready),
    .credit_i     (credit),
    .out_flit_o   (out_flit),
    .vc_locked_o  (vc_locked),
    .credit_err_o (cerr)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] mk(input int vc, input int typ,
                                     input int len, input int tag);
    logic [36:0] f;
    f        = '0;
    f[0]     = 1'b1;
    f[2:1]   = vc[1:0];
    f[33:32] = typ[1:0];
    f[29:22] = len[7:0];
    f[21:3]  = tag[18:0];
    f[31:30] = 2'b10;
    f[36:34] = 3'b101;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int n, input logic [36:0] f);
    in_flit[n*37 +: 37] = f;
  endtask

  // One cycle: check combinational ready, clock, check registered flit.
  task automatic cyc(input string tag, input logic [2:0] cr,
                     input logic [3:0] rdy, input logic [36:0] exp);
    credit = cr;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1;
    credit = '0;
    chk({tag, "_out"}, 64'(out_flit), 64'(exp));
  endtask

  logic [36:0] fa [4];
  logic [36:0] h, b1, b2, t, p, q;

  initial begin
    arst    = 1'b1;
    in_flit = '0;
    credit  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    chk("rst_out", 64'(out_flit), 64'd0);
    chk("rst_lock", 64'(vc_locked), 64'd0);
    chk("rst_err", 64'(cerr), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);

    // Single-flit round robin on VC0, credit returned every accept
    for (int n = 0; n < 4; n++) begin
      fa[n] = mk(0, 0, 0, 16'h100 + n);
      put(n, fa[n]);
    end
    for (int g = 0; g < 5; g++) begin
      cyc("rr", 3'b001, 4'(1 << (g % 4)), fa[g % 4]);
    end
    in_flit = '0;
    cyc("rr_idle", 3'b000, 4'b0000, '0);

    // Wormhole lock on VC1; prime ptr[1] to 2 first
    p = mk(1, 0, 0, 16'h211);
    put(1, p);
    cyc("wh_prime", 3'b010, 4'b0010, p);
    h  = mk(1, 0, 2, 16'h221);
    b1 = mk(1, 1, 0, 16'h222);
    t  = mk(1, 2, 0, 16'h223);
    q  = mk(1, 0, 0, 16'h201);
    in_flit = '0;
    put(2, h);
    put(0, q);
    chk("wh_lock_pre", 64'(vc_locked), 64'd0);
    cyc("wh_head", 3'b010, 4'b0100, h);
    chk("wh_lock_h", 64'(vc_locked), 64'b010);
    put(2, b1);
    cyc("wh_body", 3'b010, 4'b0100, b1);
    chk("wh_lock_b", 64'(vc_locked), 64'b010);
    put(2, t);
    cyc("wh_tail", 3'b010, 4'b0100, t);
    chk("wh_lock_t", 64'(vc_locked), 64'b000);
    put(2, '0);
    cyc("wh_next", 3'b010, 4'b0001, q);
    in_flit = '0;

    // Credit stall on VC0, input 1 packet of 4 flits
    h  = mk(0, 0, 3, 16'h331);
    b1 = mk(0, 1, 0, 16'h332);
    b2 = mk(0, 1, 0, 16'h333);
    t  = mk(0, 2, 0, 16'h334);
    put(1, h);
    cyc("st_h", 3'b000, 4'b0010, h);
    chk("st_lock", 64'(vc_locked), 64'b001);
    put(1, b1);
    cyc("st_b1", 3'b000, 4'b0010, b1);
    put(1, b2);
    cyc("st_stall", 3'b000, 4'b0000, '0);
    cyc("st_cr", 3'b001, 4'b0000, '0);
    cyc("st_b2", 3'b000, 4'b0010, b2);
    put(1, t);
    cyc("st_stall2", 3'b001, 4'b0000, '0);
    cyc("st_t", 3'b000, 4'b0010, t);
    chk("st_unlock", 64'(vc_locked), 64'b000);
    in_flit = '0;
    cyc("st_ret1", 3'b001, 4'b0000, '0);
    cyc("st_ret2", 3'b001, 4'b0000, '0);

    // VC2 beats VC0 until VC2 credits run out
    h  = mk(2, 0, 3, 16'h421);
    b1 = mk(2, 1, 0, 16'h422);
    b2 = mk(2, 1, 0, 16'h423);
    t  = mk(2, 2, 0, 16'h424);
    p  = mk(0, 0, 2, 16'h401);
    q  = mk(0, 1, 0, 16'h402);
    put(3, h);
    put(0, p);
    cyc("pr_h2", 3'b000, 4'b1000, h);
    put(3, b1);
    cyc("pr_b2a", 3'b000, 4'b1000, b1);
    put(3, b2);
    cyc("pr_h0", 3'b000, 4'b0001, p);
    put(0, q);
    cyc("pr_b0", 3'b100, 4'b0001, q);
    p = mk(0, 2, 0, 16'h403);
    put(0, p);
    cyc("pr_b2b", 3'b000, 4'b1000, b2);
    put(3, t);
    cyc("pr_none", 3'b101, 4'b0000, '0);
    cyc("pr_t2", 3'b000, 4'b1000, t);
    put(3, '0);
    cyc("pr_t0", 3'b000, 4'b0001, p);
    chk("pr_lock", 64'(vc_locked), 64'b000);
    in_flit = '0;
    cyc("pr_ret1", 3'b101, 4'b0000, '0);
    cyc("pr_ret2", 3'b101, 4'b0000, '0);
    chk("pr_err", 64'(cerr), 64'd0);

    // Credit with send leaves counter full, so one more pulse overflows
    p = mk(1, 0, 0, 16'h511);
    put(2, p);
    cyc("sim_send", 3'b010, 4'b0100, p);
    chk("sim_err0", 64'(cerr), 64'd0);
    in_flit = '0;
    cyc("sim_over", 3'b010, 4'b0000, '0);
    chk("sim_err1", 64'(cerr), 64'd1);
    cyc("sim_hold", 3'b000, 4'b0000, '0);
    chk("sim_err2", 64'(cerr), 64'd1);

    // Reset while VC0 is locked to input 3
    h = mk(0, 0, 2, 16'h631);
    put(3, h);
    cyc("rs_h", 3'b000, 4'b1000, h);
    chk("rs_lock", 64'(vc_locked), 64'b001);
    put(3, mk(0, 1, 0, 16'h632));
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    chk("rs_out", 64'(out_flit), 64'd0);
    chk("rs_lock0", 64'(vc_locked), 64'd0);
    chk("rs_err", 64'(cerr), 64'd0);
    in_flit = '0;
    p = mk(0, 0, 0, 16'h601);
    put(0, p);
    cyc("rs_new", 3'b000, 4'b0001, p);
    cyc("rs_cr2", 3'b000, 4'b0001, p);
    cyc("rs_cr0", 3'b000, 4'b0000, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
